// File: rtl/number_entry_ctrl.sv
// Two-digit keypad number entry controller.
// Accumulates up to two decimal digits, commits the value on ENTER, discards
// it on CLEAR, and abandons a partial entry after TIMEOUT_CYCLES idle cycles.
// err, timeout and number_valid are registered one-cycle strobes and are
// mutually exclusive by construction.
module number_entry_ctrl #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  output logic [6:0] entry,
  output logic [1:0] digits,
  output logic [6:0] number,
  output logic       number_valid,
  output logic       err,
  output logic       timeout
);

  // The counter saturates at its expiry value, so it never needs to hold
  // TIMEOUT_CYCLES itself; this keeps it narrow even for large intervals.
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ONE  = 2'd1,
    TWO  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_stateNext;
  logic [6:0]    r_entry;
  logic [6:0]    w_entryNext;
  logic [6:0]    r_number;
  logic [6:0]    w_numberNext;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_countNext;
  logic [CW-1:0] w_countInc;
  logic          r_err;
  logic          w_errNext;
  logic          r_timeout;
  logic          w_timeoutNext;
  logic          r_numberValid;
  logic          w_numberValidNext;

  logic          w_accept;
  logic          w_isDigit;
  logic          w_isClear;
  logic          w_isEnter;
  logic          w_isInvalid;
  logic [6:0]    w_shifted;
  logic [6:0]    w_keyWide;

  assign key_ready    = (r_state != DONE);
  assign entry        = r_entry;
  assign number       = r_number;
  assign number_valid = r_numberValid;
  assign err          = r_err;
  assign timeout      = r_timeout;

  assign w_accept    = key_valid & key_ready;
  assign w_isDigit   = (key_code <= 4'd9);
  assign w_isClear   = (key_code == 4'hA);
  assign w_isEnter   = (key_code == 4'hB);
  assign w_isInvalid = (key_code >= 4'hC);

  // Entry is at most 9 when a second digit arrives, so 7 bits never overflow.
  assign w_keyWide  = {3'b000, key_code};
  assign w_shifted  = (r_entry * 7'd10) + w_keyWide;
  // Idle counter advances but sticks at the expiry value if a non-restarting
  // (invalid) key postpones the abort.
  assign w_countInc = (r_count == LIMIT) ? r_count : r_count + 1'b1;

  // Digit count is a pure function of the state.
  always_comb begin
    digits = 2'd0;
    case (r_state)
      ONE:     digits = 2'd1;
      TWO:     digits = 2'd2;
      default: digits = 2'd0;
    endcase
  end

  // Next-state, datapath and strobe decode for every state/key combination.
  always_comb begin
    w_stateNext       = r_state;
    w_entryNext       = r_entry;
    w_numberNext      = r_number;
    w_countNext       = '0;
    w_errNext         = 1'b0;
    w_timeoutNext     = 1'b0;
    w_numberValidNext = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_isDigit) begin
            w_entryNext = w_keyWide;
            w_stateNext = ONE;
          end else if (w_isEnter || w_isInvalid) begin
            w_errNext = 1'b1;
          end
        end
      end
      ONE, TWO: begin
        w_countNext = w_countInc;
        if (w_accept) begin
          if (w_isInvalid) begin
            w_errNext = 1'b1;
          end else begin
            w_countNext = '0;
            if (w_isDigit) begin
              if (r_state == ONE) begin
                w_entryNext = w_shifted;
                w_stateNext = TWO;
              end else begin
                w_errNext = 1'b1;
              end
            end else if (w_isEnter) begin
              w_numberNext      = r_entry;
              w_numberValidNext = 1'b1;
              w_stateNext       = DONE;
            end else if (w_isClear) begin
              w_entryNext = 7'd0;
              w_stateNext = IDLE;
            end
          end
        end else if (r_count == LIMIT) begin
          w_countNext   = '0;
          w_entryNext   = 7'd0;
          w_timeoutNext = 1'b1;
          w_stateNext   = IDLE;
        end
      end
      DONE: begin
        w_entryNext = 7'd0;
        w_stateNext = IDLE;
      end
      default: begin
        w_entryNext = 7'd0;
        w_stateNext = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Datapath, idle counter and registered strobes.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_entry       <= 7'd0;
      r_number      <= 7'd0;
      r_count       <= '0;
      r_err         <= 1'b0;
      r_timeout     <= 1'b0;
      r_numberValid <= 1'b0;
    end else begin
      r_entry       <= w_entryNext;
      r_number      <= w_numberNext;
      r_count       <= w_countNext;
      r_err         <= w_errNext;
      r_timeout     <= w_timeoutNext;
      r_numberValid <= w_numberValidNext;
    end
  end

endmodule

// File: tb/tb_number_entry_ctrl.sv
// Directed testbench for number_entry_ctrl with a short idle interval.
module tb_number_entry_ctrl;

  logic       CLOCK_50;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic [6:0] entry;
  logic [1:0] digits;
  logic [6:0] number;
  logic       number_valid;
  logic       err;
  logic       timeout;

  int totalChecks = 0;
  int badChecks   = 0;

  number_entry_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ready   (key_ready),
    .entry       (entry),
    .digits      (digits),
    .number      (number),
    .number_valid(number_valid),
    .err         (err),
    .timeout     (timeout)
  );

  // 50 MHz-style free-running clock.
  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  // Safety net so the run can never hang.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    totalChecks++;
    if (observed != expected) begin
      badChecks++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Present one key for a single rising edge, then sample just after it.
  task automatic applyStimulus(input logic [3:0] code);
    @(negedge CLOCK_50);
    key_valid = 1'b1;
    key_code  = code;
    @(posedge CLOCK_50);
    #1;
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  initial begin
    int cyc;
    reset     = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    #35;
    checkOutput("rstReady", key_ready, 1);
    checkOutput("rstEntry", entry, 0);
    checkOutput("rstDigits", digits, 0);
    checkOutput("rstNumber", number, 0);
    checkOutput("rstStrobes", {number_valid, err, timeout}, 0);
    @(negedge CLOCK_50);
    reset = 1'b0;

    // 4, 2, ENTER
    applyStimulus(4'h4);
    checkOutput("e42_first", entry, 4);
    checkOutput("e42_dig1", digits, 1);
    applyStimulus(4'h2);
    checkOutput("e42_second", entry, 42);
    checkOutput("e42_dig2", digits, 2);
    applyStimulus(4'hB);
    checkOutput("e42_number", number, 42);
    checkOutput("e42_valid", number_valid, 1);
    checkOutput("e42_doneReady", key_ready, 0);
    checkOutput("e42_doneDig", digits, 0);
    waitCycles(1);
    checkOutput("e42_validEnd", number_valid, 0);
    checkOutput("e42_entryClr", entry, 0);
    checkOutput("e42_digClr", digits, 0);
    checkOutput("e42_readyBack", key_ready, 1);

    // 7, ENTER then 0, 3, ENTER
    applyStimulus(4'h7);
    applyStimulus(4'hB);
    checkOutput("n7_number", number, 7);
    checkOutput("n7_valid", number_valid, 1);
    waitCycles(1);
    applyStimulus(4'h0);
    checkOutput("n03_lead", entry, 0);
    checkOutput("n03_leadDig", digits, 1);
    applyStimulus(4'h3);
    checkOutput("n03_entry", entry, 3);
    checkOutput("n7_hold", number, 7);
    checkOutput("n7_holdValid", number_valid, 0);
    applyStimulus(4'hB);
    checkOutput("n03_number", number, 3);
    checkOutput("n03_valid", number_valid, 1);
    waitCycles(1);

    // 9, 9, 5 (rejected), ENTER, ENTER in IDLE
    applyStimulus(4'h9);
    applyStimulus(4'h9);
    checkOutput("n99_entry", entry, 99);
    applyStimulus(4'h5);
    checkOutput("n99_thirdErr", err, 1);
    checkOutput("n99_thirdEntry", entry, 99);
    checkOutput("n99_thirdDig", digits, 2);
    applyStimulus(4'hB);
    checkOutput("n99_number", number, 99);
    checkOutput("n99_valid", number_valid, 1);
    checkOutput("n99_errEnd", err, 0);
    waitCycles(1);
    applyStimulus(4'hB);
    checkOutput("idleEnterErr", err, 1);
    checkOutput("idleEnterNum", number, 99);
    checkOutput("idleEnterValid", number_valid, 0);
    waitCycles(1);
    checkOutput("errOneCycle", err, 0);

    // Idle abort: strobe 16 cycles after the digit is accepted
    applyStimulus(4'h5);
    cyc = 0;
    do begin
      waitCycles(1);
      cyc++;
    end while (!timeout && cyc < 40);
    checkOutput("toLatency", cyc, 16);
    checkOutput("toEntry", entry, 0);
    checkOutput("toDigits", digits, 0);
    checkOutput("toNumber", number, 99);
    checkOutput("toNoValid", number_valid, 0);
    waitCycles(1);
    checkOutput("toOneCycle", timeout, 0);

    // Key on the expiry cycle wins over the abort
    applyStimulus(4'h5);
    waitCycles(15);
    checkOutput("raceBefore", timeout, 0);
    applyStimulus(4'h6);
    checkOutput("raceEntry", entry, 56);
    checkOutput("raceDigits", digits, 2);
    checkOutput("raceNoTo", timeout, 0);
    waitCycles(1);
    checkOutput("raceNoToLater", timeout, 0);
    applyStimulus(4'hA);
    checkOutput("raceClear", entry, 0);

    // Invalid code, CLEAR, key during DONE, reset mid-entry
    applyStimulus(4'h3);
    applyStimulus(4'hE);
    checkOutput("badCodeErr", err, 1);
    checkOutput("badCodeEntry", entry, 3);
    checkOutput("badCodeDig", digits, 1);
    applyStimulus(4'hA);
    checkOutput("clearEntry", entry, 0);
    checkOutput("clearDig", digits, 0);
    checkOutput("clearNoErr", err, 0);
    applyStimulus(4'h1);
    applyStimulus(4'hB);
    checkOutput("n1_number", number, 1);
    applyStimulus(4'h5);
    checkOutput("doneKeyEntry", entry, 0);
    checkOutput("doneKeyDig", digits, 0);
    checkOutput("doneKeyErr", err, 0);
    applyStimulus(4'h4);
    applyStimulus(4'h5);
    checkOutput("preRstEntry", entry, 45);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("asyncRstEntry", entry, 0);
    checkOutput("asyncRstDig", digits, 0);
    checkOutput("asyncRstNum", number, 0);
    checkOutput("asyncRstReady", key_ready, 1);
    checkOutput("asyncRstStrobes", {number_valid, err, timeout}, 0);
    @(negedge CLOCK_50);
    reset = 1'b0;
    applyStimulus(4'h8);
    checkOutput("postRstKey", entry, 8);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
